// File: rtl/arch_defs_pkg.sv
// Shared SAP-2 fetch definitions: state encoding, opcode constants and the
// opcode -> instruction length table used by the fetch sequencer.
package arch_defs_pkg;

    localparam int          ADDR_W           = 16;
    localparam int          DATA_W           = 8;
    localparam logic [15:0] RESET_VECTOR_DEF = 16'hF000;

    typedef enum logic [2:0] {
        S_ADDR,
        S_WAIT,
        S_LATCH,
        S_CHK_MORE,
        S_DISPATCH,
        S_HALT
    } fetch_state_t;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_HLT   = 8'h76;
    localparam logic [7:0] OP_LDI_A = 8'h3E;
    localparam logic [7:0] OP_LDI_B = 8'h06;
    localparam logic [7:0] OP_LDI_C = 8'h0E;
    localparam logic [7:0] OP_ANI   = 8'hE6;
    localparam logic [7:0] OP_ORI   = 8'hF6;
    localparam logic [7:0] OP_XRI   = 8'hEE;
    localparam logic [7:0] OP_IN    = 8'hDB;
    localparam logic [7:0] OP_OUT   = 8'hD3;
    localparam logic [7:0] OP_JMP   = 8'hC3;
    localparam logic [7:0] OP_JZ    = 8'hCA;
    localparam logic [7:0] OP_JNZ   = 8'hC2;
    localparam logic [7:0] OP_JM    = 8'hFA;
    localparam logic [7:0] OP_CALL  = 8'hCD;
    localparam logic [7:0] OP_LDA   = 8'h3A;
    localparam logic [7:0] OP_STA   = 8'h32;

    // Unlisted opcodes are single-byte; execute decides what to do with them.
    function automatic logic [1:0] instr_len(input logic [7:0] op);
        case (op)
            OP_LDI_A, OP_LDI_B, OP_LDI_C, OP_ANI,
            OP_ORI, OP_XRI, OP_IN, OP_OUT:              instr_len = 2'd2;
            OP_JMP, OP_JZ, OP_JNZ, OP_JM,
            OP_CALL, OP_LDA, OP_STA:                    instr_len = 2'd3;
            default:                                    instr_len = 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory bus plus fetch/execute handshake between the fetch unit (master)
// and the memory/execute side (slave).
interface instruction_fetch_unit_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_rd_o;
    logic [DATA_WIDTH-1:0] mem_data_i;
    logic [DATA_WIDTH-1:0] opcode_o;
    logic [DATA_WIDTH-1:0] operand_lo_o;
    logic [DATA_WIDTH-1:0] operand_hi_o;
    logic [ADDR_WIDTH-1:0] pc_o;
    logic                  instr_valid_o;
    logic                  instr_ready_i;
    logic                  jump_en_i;
    logic [ADDR_WIDTH-1:0] jump_addr_i;
    logic                  halt_i;
    logic                  halted_o;

    modport master (
        output mem_addr_o, mem_rd_o, opcode_o, operand_lo_o, operand_hi_o,
               pc_o, instr_valid_o, halted_o,
        input  mem_data_i, instr_ready_i, jump_en_i, jump_addr_i, halt_i
    );

    modport slave (
        input  mem_addr_o, mem_rd_o, opcode_o, operand_lo_o, operand_hi_o,
               pc_o, instr_valid_o, halted_o,
        output mem_data_i, instr_ready_i, jump_en_i, jump_addr_i, halt_i
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// SAP-2 instruction fetch: walks memory one byte per 4 clocks, assembles
// opcode + operands, hands them to execute and applies jump/halt on accept.
module instruction_fetch_unit
    import arch_defs_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(RESET_VECTOR_DEF)
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);

    fetch_state_t          r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_opcode, r_lo, r_hi;
    logic [1:0]            r_byte_idx;
    logic                  w_accept, w_more;
    logic                  w_rd, w_valid, w_halted;

    assign w_accept = (r_state == S_DISPATCH) && bus.instr_ready_i;
    assign w_more   = ({1'b0, r_byte_idx} + 3'd1) < {1'b0, instr_len(r_opcode)};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_ADDR;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_rd     = 1'b0;
        w_valid  = 1'b0;
        w_halted = 1'b0;
        case (r_state)
            S_ADDR: begin
                w_rd   = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT:     w_next = S_LATCH;
            S_LATCH:    w_next = S_CHK_MORE;
            S_CHK_MORE: w_next = w_more ? S_ADDR : S_DISPATCH;
            S_DISPATCH: begin
                w_valid = 1'b1;
                if (w_accept) w_next = bus.halt_i ? S_HALT : S_ADDR;
            end
            S_HALT:     w_halted = 1'b1;
            default:    w_next = S_ADDR;
        endcase
    end

    // Byte 0 selects the length, so operand bytes always see the new opcode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_VECTOR;
            r_opcode   <= '0;
            r_lo       <= '0;
            r_hi       <= '0;
            r_byte_idx <= 2'd0;
        end else begin
            case (r_state)
                S_LATCH: begin
                    case (r_byte_idx)
                        2'd0:    r_opcode <= bus.mem_data_i;
                        2'd1:    r_lo     <= bus.mem_data_i;
                        default: r_hi     <= bus.mem_data_i;
                    endcase
                    r_pc <= r_pc + ADDR_WIDTH'(1);
                end
                S_CHK_MORE: r_byte_idx <= w_more ? r_byte_idx + 2'd1 : 2'd0;
                S_DISPATCH: begin
                    if (w_accept && !bus.halt_i && bus.jump_en_i)
                        r_pc <= bus.jump_addr_i;
                end
                default: ;
            endcase
        end
    end

    // The state register idles in S_ADDR during reset; keep the strobe low there.
    assign bus.mem_rd_o      = w_rd && reset;
    assign bus.mem_addr_o    = r_pc;
    assign bus.pc_o          = r_pc;
    assign bus.opcode_o      = r_opcode;
    assign bus.operand_lo_o  = r_lo;
    assign bus.operand_hi_o  = r_hi;
    assign bus.instr_valid_o = w_valid;
    assign bus.halted_o      = w_halted;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed + random bench for instruction_fetch_unit against a byte-level
// model of program memory and the fetch/jump/halt rules.
module tb_instruction_fetch_unit;

    logic clk;
    logic reset;
    logic [7:0] rdata;
    logic [7:0] mem [0:65535];
    logic [15:0] rdq [$];
    int len_tbl [256];

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] exp_pc;
    logic [7:0]  exp_op, exp_lo, exp_hi;

    instruction_fetch_unit_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

    instruction_fetch_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: data appears the cycle after the strobe and holds.
    always @(posedge clk) begin
        if (bus.mem_rd_o === 1'b1) begin
            rdata <= mem[bus.mem_addr_o];
            rdq.push_back(bus.mem_addr_o);
        end
    end
    assign bus.mem_data_i = rdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc = 16'hF000;
        exp_op = 8'h00;
        exp_lo = 8'h00;
        exp_hi = 8'h00;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        #1;
        chk("rst_pc",     bus.pc_o, 16'hF000);
        chk("rst_valid",  bus.instr_valid_o, 1'b0);
        chk("rst_halted", bus.halted_o, 1'b0);
        chk("rst_rd",     bus.mem_rd_o, 1'b0);
        chk("rst_regs",   {bus.opcode_o, bus.operand_lo_o, bus.operand_hi_o}, 24'h0);
        tick();
        tick();
        reset = 1'b1;
        rdq.delete();
        model_reset();
    endtask

    // Fetch one instruction from exp_pc, check it, then accept with the given action.
    task automatic run_instr(input int dly, input bit do_jmp, input logic [15:0] jaddr,
                             input bit do_halt);
        logic [7:0]  op, lo, hi;
        logic [15:0] a;
        int n, cyc;
        op = mem[exp_pc];
        n  = len_tbl[op];
        a  = exp_pc + 16'd1;
        lo = (n >= 2) ? mem[a] : exp_lo;
        a  = exp_pc + 16'd2;
        hi = (n == 3) ? mem[a] : exp_hi;
        cyc = 0;
        while (bus.instr_valid_o !== 1'b1 && cyc < 64) begin
            tick();
            cyc++;
        end
        chk("latency", cyc, 4 * n);
        chk("opcode",  bus.opcode_o, op);
        chk("op_lo",   bus.operand_lo_o, lo);
        chk("op_hi",   bus.operand_hi_o, hi);
        a = exp_pc + 16'(n);
        chk("pc_disp", bus.pc_o, a);
        chk("rd_count", rdq.size(), n);
        for (int k = 0; k < n && k < rdq.size(); k++) begin
            a = exp_pc + 16'(k);
            chk("rd_addr", rdq[k], a);
        end
        // Jump/halt offered while ready is low must be ignored.
        bus.jump_en_i   = 1'b1;
        bus.halt_i      = 1'b1;
        bus.jump_addr_i = 16'($urandom);
        for (int d = 0; d < dly; d++) begin
            tick();
            chk("hold", {bus.instr_valid_o, bus.opcode_o, bus.operand_lo_o, bus.operand_hi_o,
                         bus.mem_rd_o}, {1'b1, op, lo, hi, 1'b0});
        end
        bus.instr_ready_i = 1'b1;
        bus.jump_en_i     = do_jmp;
        bus.jump_addr_i   = jaddr;
        bus.halt_i        = do_halt;
        tick();
        bus.instr_ready_i = 1'b0;
        bus.jump_en_i     = 1'b0;
        bus.halt_i        = 1'b0;
        rdq.delete();
        exp_op = op;
        exp_lo = lo;
        exp_hi = hi;
        exp_pc = (do_jmp && !do_halt) ? jaddr : exp_pc + 16'(n);
        if (!do_halt) begin
            chk("next_addr", bus.mem_addr_o, exp_pc);
            chk("next_rd",   bus.mem_rd_o, 1'b1);
        end
    endtask

    initial begin
        automatic int two_b [8]   = '{'h3E, 'h06, 'h0E, 'hE6, 'hF6, 'hEE, 'hDB, 'hD3};
        automatic int three_b [7] = '{'hC3, 'hCA, 'hC2, 'hFA, 'hCD, 'h3A, 'h32};
        for (int i = 0; i < 256; i++) len_tbl[i] = 1;
        foreach (two_b[i])   len_tbl[two_b[i]] = 2;
        foreach (three_b[i]) len_tbl[three_b[i]] = 3;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        mem[16'hF000] = 8'h3E; mem[16'hF001] = 8'hFF;
        mem[16'hF002] = 8'h00; mem[16'hF003] = 8'h00;
        mem[16'hF004] = 8'hCA; mem[16'hF005] = 8'h09; mem[16'hF006] = 8'hF0;
        mem[16'hF007] = 8'hAB;
        mem[16'hF008] = 8'h76;
        mem[16'hF009] = 8'hC3; mem[16'hF00A] = 8'h04; mem[16'hF00B] = 8'hF0;
        mem[16'hFFFF] = 8'h3E; mem[16'h0000] = 8'h5A;
        mem[16'h0001] = 8'h3E; mem[16'h0002] = 8'h77;

        reset = 1'b0;
        bus.instr_ready_i = 1'b0;
        bus.jump_en_i     = 1'b0;
        bus.jump_addr_i   = 16'h0000;
        bus.halt_i        = 1'b0;
        tick();
        reset_dut();

        run_instr(0, 1'b0, 16'h0000, 1'b0);          // LDI_A FF, 8 clocks
        run_instr(1, 1'b0, 16'h0000, 1'b0);          // NOP
        run_instr(0, 1'b0, 16'h0000, 1'b0);          // NOP
        run_instr(0, 1'b1, 16'hF009, 1'b0);          // JZ taken -> F009
        run_instr(2, 1'b1, 16'hF004, 1'b0);          // JMP back to F004
        run_instr(5, 1'b0, 16'h0000, 1'b0);          // JZ not taken, long hold
        run_instr(0, 1'b0, 16'h0000, 1'b0);          // unknown opcode, stale operands
        run_instr(0, 1'b1, 16'h1234, 1'b1);          // HLT: halt beats jump

        for (int i = 0; i < 24; i++) begin
            bus.instr_ready_i = 1'(i % 2);
            bus.jump_en_i     = 1'b1;
            bus.jump_addr_i   = 16'h4321;
            tick();
            chk("halted", {bus.halted_o, bus.instr_valid_o, bus.mem_rd_o, bus.pc_o},
                {1'b1, 1'b0, 1'b0, 16'hF009});
        end
        bus.instr_ready_i = 1'b0;
        bus.jump_en_i     = 1'b0;
        chk("halt_no_rd", rdq.size(), 0);

        reset_dut();
        run_instr(0, 1'b1, 16'hFFFF, 1'b0);          // LDI_A FF, jump to FFFF
        run_instr(0, 1'b0, 16'h0000, 1'b0);          // 2-byte across the wrap
        for (int i = 0; i < 5; i++) tick();          // into WAIT of operand byte
        chk("mid_pc", bus.pc_o, 16'h0002);
        reset = 1'b0;
        #1;
        chk("abort_pc",    bus.pc_o, 16'hF000);
        chk("abort_valid", bus.instr_valid_o, 1'b0);
        chk("abort_rd",    bus.mem_rd_o, 1'b0);
        chk("abort_op",    bus.opcode_o, 8'h00);
        tick();
        reset = 1'b1;
        rdq.delete();
        model_reset();
        run_instr(0, 1'b0, 16'h0000, 1'b0);          // refetch from F000

        for (int i = 0; i < 60; i++) begin
            run_instr($urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                      16'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
